// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer and auto-incrementing
// write/read bursts toward local register logic.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_stb,
  output logic       rd_stb,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned    CW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f, scl_d, sda_d;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_rise, scl_fall, start_c, stop_c;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, sh_in;
  logic       rw, rw_n;
  logic       rd_pend, rd_pend_n;
  logic [7:0] reg_addr_n, wr_data_n;
  logic       wr_stb_n, rd_stb_n, sda_oe_n, busy_n;

  // Synchronise the pins, reject runs shorter than FILTER_LEN, keep last level for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == LAST) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == LAST) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = sda_d & ~sda_f & scl_f & scl_d;
  assign stop_c   = ~sda_d & sda_f & scl_f & scl_d;
  assign sh_in    = {shreg[6:0], sda_f};

  // Register FSM state and all protocol outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      rd_pend  <= 1'b0;
      reg_addr <= '0;
      wr_data  <= '0;
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      rw       <= rw_n;
      rd_pend  <= rd_pend_n;
      reg_addr <= reg_addr_n;
      wr_data  <= wr_data_n;
      wr_stb   <= wr_stb_n;
      rd_stb   <= rd_stb_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
    end
  end

  // Next-state logic; ACK states are entered on the 8th SCL fall so the ACK is
  // driven through the whole 9th clock and released on its fall
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    rw_n       = rw;
    rd_pend_n  = rd_stb;
    reg_addr_n = reg_addr;
    wr_data_n  = wr_data;
    wr_stb_n   = 1'b0;
    rd_stb_n   = 1'b0;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    if (stop_c) begin
      state_n   = IDLE;
      busy_n    = 1'b0;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
    end else if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE, IGNORE: sda_oe_n = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            shreg_n   = sh_in;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == DEV_ADDR) begin
              state_n  = ADDR_ACK;
              busy_n   = 1'b1;
              sda_oe_n = 1'b1;
              rw_n     = shreg[0];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (rw) begin
              rd_stb_n = 1'b1;
              state_n  = RDATA;
            end else begin
              state_n = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shreg_n   = sh_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) reg_addr_n = sh_in;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n  = PTR_ACK;
            sda_oe_n = 1'b1;
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_n   = sh_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              wr_stb_n  = 1'b1;
              wr_data_n = sh_in;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n  = WDATA_ACK;
            sda_oe_n = 1'b1;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n   = 1'b0;
            bit_cnt_n  = '0;
            reg_addr_n = reg_addr + 8'd1;
            state_n    = WDATA;
          end
        end
        RDATA: begin
          if (rd_pend) begin
            shreg_n  = rd_data;
            sda_oe_n = ~rd_data[7];
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n  = RDATA_ACK;
              sda_oe_n = 1'b0;
            end else if (bit_cnt != 4'd0) begin
              shreg_n  = {shreg[6:0], 1'b1};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        RDATA_ACK: begin
          sda_oe_n = 1'b0;
          if (scl_rise) begin
            shreg_n = sh_in;
          end else if (scl_fall) begin
            bit_cnt_n = '0;
            if (!shreg[0]) begin
              reg_addr_n = reg_addr + 8'd1;
              rd_stb_n   = 1'b1;
              state_n    = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench for i2c_target_regs: an initiator model drives SCL/SDA,
// a scoreboard checks every wr_stb/rd_stb against queued expectations.
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_i, sda_i, sda_oe;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_stb, rd_stb, busy;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  bit         glitch_en = 1'b0;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mem [256];
  int         checks   = 0;
  int         failures = 0;

  assign scl_i = scl_drv;
  assign sda_i = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h1A), .FILTER_LEN(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_stb   (wr_stb),
    .rd_stb   (rd_stb),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Local register model: data valid only in the clk after rd_stb
  always @(posedge clk) rd_data <= rd_stb ? mem[reg_addr] : 8'hEE;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (wr_stb === 1'b1 || rd_stb === 1'b1) begin
      if (wr_stb === 1'b1 && rd_stb === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL strobe_overlap: got wr_stb=1 rd_stb=1 expected at most one");
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=%02h expected none",
                 wr_stb, rd_stb, reg_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check8("strobe_kind", 8'(wr_stb), 8'(mon_e.is_wr));
        check8("strobe_addr", reg_addr, mon_e.addr);
        if (mon_e.is_wr) check8("wr_data", wr_data, mon_e.data);
      end
    end
  end

  task automatic push(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    clks(10);
    sda_drv = b;
    if (glitch_en) begin
      clks(4); scl_drv = 1'b1; clks(1); scl_drv = 1'b0; clks(5);
    end else begin
      clks(10);
    end
    scl_drv = 1'b1;
    if (glitch_en) begin
      clks(4); sda_drv = ~b; clks(1); sda_drv = b; clks(5);
    end else begin
      clks(10);
    end
    s = sda_i;
    clks(10);
    scl_drv = 1'b0;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1;
    clks(10);
    scl_drv = 1'b1;
    clks(20);
    sda_drv = 1'b0;
    clks(20);
    scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    clks(10);
    sda_drv = 1'b0;
    clks(10);
    scl_drv = 1'b1;
    clks(20);
    sda_drv = 1'b1;
    clks(20);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [5:0] tail;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h96;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    mem[8'h30] = 8'h00;

    rst = 1'b1;
    clks(5);
    check8("rst_sda_oe", 8'(sda_oe), 8'h00);
    check8("rst_busy", 8'(busy), 8'h00);
    check8("rst_wr_stb", 8'(wr_stb), 8'h00);
    check8("rst_rd_stb", 8'(rd_stb), 8'h00);
    check8("rst_reg_addr", reg_addr, 8'h00);
    check8("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    clks(20);

    // 1: write burst 0x10 <- A5, 5A
    push(1'b1, 8'h10, 8'hA5);
    push(1'b1, 8'h11, 8'h5A);
    bus_start();
    write_byte(8'h34, ack); check8("t1_addr_ack", 8'(ack), 8'h00);
    check8("t1_busy", 8'(busy), 8'h01);
    write_byte(8'h10, ack); check8("t1_ptr_ack", 8'(ack), 8'h00);
    write_byte(8'hA5, ack); check8("t1_d0_ack", 8'(ack), 8'h00);
    write_byte(8'h5A, ack); check8("t1_d1_ack", 8'(ack), 8'h00);
    bus_stop();
    check8("t1_busy_after_stop", 8'(busy), 8'h00);
    check8("t1_sda_oe_idle", 8'(sda_oe), 8'h00);

    // 2: set pointer 0x20, repeated START, read two bytes
    bus_start();
    write_byte(8'h34, ack); check8("t2_addr_ack", 8'(ack), 8'h00);
    write_byte(8'h20, ack); check8("t2_ptr_ack", 8'(ack), 8'h00);
    push(1'b0, 8'h20, 8'h00);
    push(1'b0, 8'h21, 8'h00);
    bus_start();
    write_byte(8'h35, ack); check8("t2_raddr_ack", 8'(ack), 8'h00);
    read_byte(d, 1'b0); check8("t2_rd0", d, 8'h3C);
    read_byte(d, 1'b1); check8("t2_rd1", d, 8'hC3);
    bus_stop();
    check8("t2_busy_after_stop", 8'(busy), 8'h00);

    // 3: wrong address is ignored
    bus_start();
    write_byte(8'h36, ack); check8("t3_addr_nack", 8'(ack), 8'h01);
    check8("t3_busy", 8'(busy), 8'h00);
    write_byte(8'h00, ack); check8("t3_data_nack", 8'(ack), 8'h01);
    check8("t3_busy2", 8'(busy), 8'h00);
    bus_stop();

    // 4: pointer wraps FF -> 00
    push(1'b1, 8'hFF, 8'h01);
    push(1'b1, 8'h00, 8'h02);
    bus_start();
    write_byte(8'h34, ack); check8("t4_addr_ack", 8'(ack), 8'h00);
    write_byte(8'hFF, ack); check8("t4_ptr_ack", 8'(ack), 8'h00);
    write_byte(8'h01, ack); check8("t4_d0_ack", 8'(ack), 8'h00);
    write_byte(8'h02, ack); check8("t4_d1_ack", 8'(ack), 8'h00);
    bus_stop();

    // 5a: STOP after 4 data bits discards the byte
    bus_start();
    write_byte(8'h34, ack); check8("t5_addr_ack", 8'(ack), 8'h00);
    write_byte(8'h30, ack); check8("t5_ptr_ack", 8'(ack), 8'h00);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
    bus_stop();
    check8("t5_busy_after_stop", 8'(busy), 8'h00);

    // 5b: reset in the middle of a read byte
    push(1'b0, 8'h30, 8'h00);
    bus_start();
    write_byte(8'h35, ack); check8("t5_raddr_ack", 8'(ack), 8'h00);
    for (int i = 0; i < 3; i++) begin
      bus_bit(1'b1, s);
      check8("t5_rd_bit", 8'(s), 8'h00);
    end
    clks(12);
    check8("t5_driving_before_rst", 8'(sda_oe), 8'h01);
    rst = 1'b1;
    clks(1);
    check8("t5_sda_oe_after_rst", 8'(sda_oe), 8'h00);
    check8("t5_busy_after_rst", 8'(busy), 8'h00);
    check8("t5_reg_addr_after_rst", reg_addr, 8'h00);
    rst = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      bus_bit(1'b1, s);
      tail[i] = s;
    end
    check8("t5_released_tail", 8'(tail), 8'h3F);
    bus_stop();

    // 6: scenario 1 again with 1-clk SCL and SDA glitches on every bit
    push(1'b1, 8'h10, 8'hA5);
    push(1'b1, 8'h11, 8'h5A);
    bus_start();
    glitch_en = 1'b1;
    write_byte(8'h34, ack); check8("t6_addr_ack", 8'(ack), 8'h00);
    write_byte(8'h10, ack); check8("t6_ptr_ack", 8'(ack), 8'h00);
    write_byte(8'hA5, ack); check8("t6_d0_ack", 8'(ack), 8'h00);
    write_byte(8'h5A, ack); check8("t6_d1_ack", 8'(ack), 8'h00);
    glitch_en = 1'b0;
    bus_stop();
    check8("t6_busy_after_stop", 8'(busy), 8'h00);

    clks(20);
    check8("pending_expect", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
